// File: rtl/fetch_unit.sv
// fetch_unit: program counter and instruction-fetch sequencer for the 8-bit
// lab processor. The sequencer starts a program at a given address. It then
// advances the PC, or redirects it to a branch target, once per retired
// instruction, and it stops when the decoder flags a halt. It also keeps a
// saturating count of retired instructions.
module fetch_unit #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [PC_W-1:0]  startAddr_i,
  input  logic             branch_taken_i,
  input  logic [PC_W-1:0]  target_i,
  input  logic             halt_i,
  input  logic             stall_i,
  output logic [PC_W-1:0]  pc_o,
  output logic             fetch_valid_o,
  output logic             done_o,
  output logic [CNT_W-1:0] retired_o,
  output logic             redirect_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t state;

  localparam logic [PC_W-1:0]  PC_ONE   = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [PC_W-1:0]  PC_ZERO  = {PC_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  // Saturating increment: once the counter reaches all-ones it stays there
  // instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    if (&value) begin
      return value;
    end else begin
      return value + CNT_ONE;
    end
  endfunction

  // Sequencer state, PC, retire counter and state-decoded flags.
  // The flags are kept as flops alongside the state, so every output is registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      pc_o          <= PC_ZERO;
      retired_o     <= CNT_ZERO;
      fetch_valid_o <= 1'b0;
      done_o        <= 1'b0;
      redirect_o    <= 1'b0;
    end else begin
      case (state)
        // IDLE and HALT behave the same way on a start request; in HALT,
        // done_o stays high until that request arrives.
        IDLE, HALT: begin
          if (start_i) begin
            state         <= RUN;
            pc_o          <= startAddr_i;
            retired_o     <= CNT_ZERO;
            fetch_valid_o <= 1'b1;
            done_o        <= 1'b0;
            redirect_o    <= 1'b0;
          end
        end
        RUN: begin
          // A stalled cycle retires nothing, so every register holds,
          // redirect_o included. A start request is ignored while running.
          if (!stall_i) begin
            retired_o <= sat_inc(retired_o);
            if (halt_i) begin
              state         <= HALT;
              fetch_valid_o <= 1'b0;
              done_o        <= 1'b1;
              redirect_o    <= 1'b0;
            end else if (branch_taken_i) begin
              pc_o       <= target_i;
              redirect_o <= 1'b1;
            end else begin
              pc_o       <= pc_o + PC_ONE;
              redirect_o <= 1'b0;
            end
          end
        end
        default: begin
          state         <= IDLE;
          pc_o          <= PC_ZERO;
          retired_o     <= CNT_ZERO;
          fetch_valid_o <= 1'b0;
          done_o        <= 1'b0;
          redirect_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed, table-driven bench for fetch_unit. It also has
// hand-written sequences for asynchronous reset and counter saturation; a
// second instance with a 4-bit counter covers saturation.
module tb_fetch_unit;

  logic       clk;
  logic       reset;
  logic       start_i;
  logic [7:0] startAddr_i;
  logic       branch_taken_i;
  logic [7:0] target_i;
  logic       halt_i;
  logic       stall_i;

  logic [7:0]  pc_o;
  logic        fetch_valid_o;
  logic        done_o;
  logic [15:0] retired_o;
  logic        redirect_o;

  logic [7:0]  pc_s;
  logic        fetch_valid_s;
  logic        done_s;
  logic [3:0]  retired_s;
  logic        redirect_s;

  int checks;
  int errors;

  fetch_unit #(.PC_W(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .startAddr_i(startAddr_i),
    .branch_taken_i(branch_taken_i), .target_i(target_i), .halt_i(halt_i),
    .stall_i(stall_i), .pc_o(pc_o), .fetch_valid_o(fetch_valid_o),
    .done_o(done_o), .retired_o(retired_o), .redirect_o(redirect_o)
  );

  fetch_unit #(.PC_W(8), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .start_i(start_i), .startAddr_i(startAddr_i),
    .branch_taken_i(branch_taken_i), .target_i(target_i), .halt_i(halt_i),
    .stall_i(stall_i), .pc_o(pc_s), .fetch_valid_o(fetch_valid_s),
    .done_o(done_s), .retired_o(retired_s), .redirect_o(redirect_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic [7:0]  addr;
    logic        br;
    logic [7:0]  tgt;
    logic        halt;
    logic        stall;
    logic [7:0]  pc;
    logic        valid;
    logic        done;
    logic [15:0] ret;
    logic        red;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic start, input logic [7:0] addr,
                              input logic br, input logic [7:0] tgt,
                              input logic halt, input logic stall,
                              input logic [7:0] pc, input logic valid,
                              input logic done, input logic [15:0] ret,
                              input logic red);
    vec_t v;
    v.start = start; v.addr = addr; v.br = br; v.tgt = tgt; v.halt = halt;
    v.stall = stall; v.pc = pc; v.valid = valid; v.done = done; v.ret = ret;
    v.red = red;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    start_i = 1'b0; startAddr_i = 8'h00; branch_taken_i = 1'b0;
    target_i = 8'h00; halt_i = 1'b0; stall_i = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_inputs();
    reset = 1'b1;

    // Table: inputs applied before an edge, expected outputs after it.
    //              st   addr  br   tgt   hlt  stl   pc   v    d    ret     red
    vq.push_back(mk(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'd0, 1'b0));
    vq.push_back(mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 16'd1, 1'b0));
    vq.push_back(mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0, 16'd2, 1'b0));
    vq.push_back(mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h03, 1'b1, 1'b0, 16'd3, 1'b0));
    vq.push_back(mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h04, 1'b1, 1'b0, 16'd4, 1'b0));
    vq.push_back(mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h05, 1'b1, 1'b0, 16'd5, 1'b0));
    vq.push_back(mk(1'b1, 8'h40, 1'b0, 8'h00, 1'b0, 1'b0, 8'h06, 1'b1, 1'b0, 16'd6, 1'b0)); // start ignored in RUN
    vq.push_back(mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h06, 1'b0, 1'b1, 16'd7, 1'b0)); // halt
    vq.push_back(mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h06, 1'b0, 1'b1, 16'd7, 1'b0)); // HALT holds
    vq.push_back(mk(1'b1, 8'h40, 1'b0, 8'h00, 1'b0, 1'b0, 8'h40, 1'b1, 1'b0, 16'd0, 1'b0)); // restart at 0x40
    vq.push_back(mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h41, 1'b1, 1'b0, 16'd1, 1'b0));
    vq.push_back(mk(1'b0, 8'h00, 1'b1, 8'h52, 1'b0, 1'b0, 8'h52, 1'b1, 1'b0, 16'd2, 1'b1)); // branch
    vq.push_back(mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h53, 1'b1, 1'b0, 16'd3, 1'b0));
    vq.push_back(mk(1'b0, 8'h00, 1'b1, 8'h10, 1'b0, 1'b0, 8'h10, 1'b1, 1'b0, 16'd4, 1'b1));
    vq.push_back(mk(1'b0, 8'h00, 1'b1, 8'h77, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 16'd4, 1'b1)); // stall
    vq.push_back(mk(1'b0, 8'h00, 1'b1, 8'h77, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 16'd4, 1'b1));
    vq.push_back(mk(1'b0, 8'h00, 1'b1, 8'h77, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 16'd4, 1'b1));
    vq.push_back(mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 16'd5, 1'b0)); // release
    vq.push_back(mk(1'b0, 8'h00, 1'b1, 8'h54, 1'b0, 1'b0, 8'h54, 1'b1, 1'b0, 16'd6, 1'b1));
    vq.push_back(mk(1'b0, 8'h00, 1'b1, 8'h99, 1'b1, 1'b0, 8'h54, 1'b0, 1'b1, 16'd7, 1'b0)); // halt beats branch
    vq.push_back(mk(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'd0, 1'b0)); // restart
    vq.push_back(mk(1'b1, 8'hFE, 1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 16'd1, 1'b0)); // start ignored
    vq.push_back(mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b1, 16'd2, 1'b0));
    vq.push_back(mk(1'b1, 8'hFE, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFE, 1'b1, 1'b0, 16'd0, 1'b0)); // start at 0xFE
    vq.push_back(mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 16'd1, 1'b0));
    vq.push_back(mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'd2, 1'b0)); // wrap
    vq.push_back(mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 16'd3, 1'b0));
    vq.push_back(mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 16'd3, 1'b0)); // stall masks halt

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset pc", {24'd0, pc_o}, 32'h00);
    check("reset valid", {31'd0, fetch_valid_o}, 32'd0);
    check("reset done", {31'd0, done_o}, 32'd0);
    check("reset retired", {16'd0, retired_o}, 32'd0);
    check("reset redirect", {31'd0, redirect_o}, 32'd0);

    for (int i = 0; i < vq.size(); i++) begin
      start_i = vq[i].start; startAddr_i = vq[i].addr;
      branch_taken_i = vq[i].br; target_i = vq[i].tgt;
      halt_i = vq[i].halt; stall_i = vq[i].stall;
      @(posedge clk);
      #1;
      check($sformatf("row%0d pc", i), {24'd0, pc_o}, {24'd0, vq[i].pc});
      check($sformatf("row%0d valid", i), {31'd0, fetch_valid_o}, {31'd0, vq[i].valid});
      check($sformatf("row%0d done", i), {31'd0, done_o}, {31'd0, vq[i].done});
      check($sformatf("row%0d retired", i), {16'd0, retired_o}, {16'd0, vq[i].ret});
      check($sformatf("row%0d redirect", i), {31'd0, redirect_o}, {31'd0, vq[i].red});
    end
    clear_inputs();

    // Asynchronous reset in mid-cycle takes effect without waiting for an edge.
    #2;
    reset = 1'b1;
    #1;
    check("async pc", {24'd0, pc_o}, 32'h00);
    check("async valid", {31'd0, fetch_valid_o}, 32'd0);
    check("async retired", {16'd0, retired_o}, 32'd0);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post-reset idle pc", {24'd0, pc_o}, 32'h00);
    check("post-reset idle valid", {31'd0, fetch_valid_o}, 32'd0);
    check("post-reset idle retired", {16'd0, retired_o}, 32'd0);

    // Saturation: 20 retires, with the 4-bit counter stopping at 15.
    start_i = 1'b1;
    startAddr_i = 8'h00;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    check("sat start retired", {28'd0, retired_s}, 32'd0);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (k == 15 || k == 16) begin
        check($sformatf("sat retired after %0d", k), {28'd0, retired_s}, 32'd15);
      end
    end
    check("sat final retired", {28'd0, retired_s}, 32'd15);
    check("sat final pc", {24'd0, pc_s}, 32'h14);
    check("wide final retired", {16'd0, retired_o}, 32'd20);
    check("wide final pc", {24'd0, pc_o}, 32'h14);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
